mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 218 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Data-memory access unit: turns a MEM-stage load/store into one word-wide bus transaction.
// Latency: with zero-wait memory, stall is high for 2 cycles and rdata is valid in the third; aborts after TIMEOUT wait cycles.
// Backpressure: holds the pipeline with stall while a request is outstanding; misaligned accesses never stall.
//
// Ports:
//   clk, reset            - sole clock; asynchronous active-low reset
//   addr, wdata, byteen   - EX/MEM address, store data and access size code
//   mem_read, mem_write   - load / store present in MEM (both high = store)
//   bus_ack, bus_rdata    - memory completion pulse and read word
//   stall                 - freeze request to EX/MEM and upstream stages
//   rdata                 - extended load result for MEM/WB
//   bus_req, bus_we, bus_addr, bus_be, bus_wdata - word-aligned bus request
//   adel, ades, bus_err   - load misalign, store misalign, timeout pulses
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  byteen,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  output logic        adel,
  output logic        ades,
  output logic        bus_err
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  wait_cnt;
  logic [1:0]  lane_q;
  logic [2:0]  size_q;

  logic        is_half;
  logic        is_byte;
  logic        is_store;
  logic        misalign;
  logic        access;
  logic        accept;
  logic        timeout_hit;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_lane;
  logic [15:0] ld_half;
  logic [7:0]  ld_byte;
  logic [31:0] ld_val;

  // Access decode. The cycle carrying bus_err still has the aborted
  // instruction sitting in EX/MEM; it must not be re-accepted, so access
  // is masked for that one cycle and the instruction moves on with stall=0.
  always_comb begin
    is_half  = (byteen == 3'b001) || (byteen == 3'b010);
    is_byte  = (byteen == 3'b011) || (byteen == 3'b100);
    is_store = mem_write;
    if (is_byte) begin
      misalign = 1'b0;
    end else if (is_half) begin
      misalign = addr[0];
    end else begin
      misalign = (addr[1:0] != 2'b00);
    end
    access = reset && !bus_err && (mem_read || mem_write);
  end

  // Lane enables and replicated store data.
  always_comb begin
    if (is_byte) begin
      be_nxt     = 4'b0001 << addr[1:0];
      wdata_lane = {4{wdata[7:0]}};
    end else if (is_half) begin
      be_nxt     = 4'b0011 << addr[1:0];
      wdata_lane = {2{wdata[15:0]}};
    end else begin
      be_nxt     = 4'b1111;
      wdata_lane = wdata;
    end
  end

  // Load extraction uses the lane/size captured at accept, never the live
  // EX/MEM inputs, which may change while the pipeline is frozen.
  always_comb begin
    ld_half = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (lane_q)
      2'd0:    ld_byte = bus_rdata[7:0];
      2'd1:    ld_byte = bus_rdata[15:8];
      2'd2:    ld_byte = bus_rdata[23:16];
      default: ld_byte = bus_rdata[31:24];
    endcase
    case (size_q)
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_val = {16'h0000, ld_half};
      3'b011:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_val = {24'h000000, ld_byte};
      default: ld_val = bus_rdata;
    endcase
  end

  assign timeout_hit = (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    bus_req   = 1'b0;
    adel      = 1'b0;
    ades      = 1'b0;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (access) begin
          if (misalign) begin
            adel = !is_store;
            ades = is_store;
          end else begin
            stall     = 1'b1;
            accept    = 1'b1;
            state_nxt = S_REQ;
          end
        end
      end
      S_REQ: begin
        bus_req   = 1'b1;
        stall     = 1'b1;
        state_nxt = bus_ack ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        bus_req = 1'b1;
        stall   = 1'b1;
        if (bus_ack) begin
          state_nxt = S_DONE;
        end else if (timeout_hit) begin
          state_nxt = S_IDLE;
        end
      end
      // DONE always returns to IDLE: stall is low here, so the instruction
      // leaves EX/MEM at this edge and is never issued twice.
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      bus_we    <= 1'b0;
      lane_q    <= '0;
      size_q    <= '0;
      wait_cnt  <= '0;
      rdata     <= '0;
      bus_err   <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      if (accept) begin
        bus_addr  <= {addr[31:2], 2'b00};
        bus_be    <= be_nxt;
        bus_wdata <= wdata_lane;
        bus_we    <= is_store;
        lane_q    <= addr[1:0];
        size_q    <= byteen;
      end
      case (state)
        S_REQ: begin
          wait_cnt <= '0;
          if (bus_ack && !bus_we) begin
            rdata <= ld_val;
          end
        end
        S_WAIT: begin
          if (bus_ack) begin
            if (!bus_we) begin
              rdata <= ld_val;
            end
          end else if (timeout_hit) begin
            bus_err  <= 1'b1;
            rdata    <= '0;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit (TIMEOUT=4): scoreboard of expected bus requests and load results.
// Inputs are driven on the falling edge; outputs are sampled 2 time units later.
// Memory responder acks after a chosen number of wait cycles, or never for the timeout case.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  byteen;
  logic        mem_read;
  logic        mem_write;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        stall;
  logic [31:0] rdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        adel;
  logic        ades;
  logic        bus_err;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] last_rdata = '0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .wdata     (wdata),
    .byteen    (byteen),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata),
    .stall     (stall),
    .rdata     (rdata),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .adel      (adel),
    .ades      (ades),
    .bus_err   (bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                          input logic we, input logic [31:0] rd);
    exp_t e;
    e.addr  = a;
    e.be    = be;
    e.wdata = wd;
    e.we    = we;
    e.rdata = rd;
    exp_q.push_back(e);
    last_rdata = rd;
  endtask

  // Reference model for the randomized accesses.
  function automatic exp_t model(input logic wr, input logic [2:0] code, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [31:0] mem_word);
    exp_t        e;
    logic [15:0] h;
    logic [7:0]  b;
    e.addr  = {a[31:2], 2'b00};
    e.we    = wr;
    e.rdata = last_rdata;
    h = a[1] ? mem_word[31:16] : mem_word[15:0];
    case (a[1:0])
      2'd0:    b = mem_word[7:0];
      2'd1:    b = mem_word[15:8];
      2'd2:    b = mem_word[23:16];
      default: b = mem_word[31:24];
    endcase
    case (code)
      3'b001, 3'b010: begin
        e.be    = a[1] ? 4'b1100 : 4'b0011;
        e.wdata = {wd[15:0], wd[15:0]};
        if (!wr) e.rdata = (code == 3'b001) ? {{16{h[15]}}, h} : {16'h0000, h};
      end
      3'b011, 3'b100: begin
        case (a[1:0])
          2'd0:    e.be = 4'b0001;
          2'd1:    e.be = 4'b0010;
          2'd2:    e.be = 4'b0100;
          default: e.be = 4'b1000;
        endcase
        e.wdata = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
        if (!wr) e.rdata = (code == 3'b011) ? {{24{b[7]}}, b} : {24'h000000, b};
      end
      default: begin
        e.be    = 4'b1111;
        e.wdata = wd;
        if (!wr) e.rdata = mem_word;
      end
    endcase
    return e;
  endfunction

  // One aligned access; memory acks in the (waits+1)-th bus_req cycle.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] code,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] mem_word, input int waits);
    exp_t e;
    int   stalls;
    int   reqs;
    bit   got;
    bit   done;
    e = '0; stalls = 0; reqs = 0; got = 1'b0; done = 1'b0;
    @(negedge clk);
    mem_read = rd; mem_write = wr; byteen = code; addr = a; wdata = wd; bus_ack = 1'b0;
    #2;
    chk("idle_stall", 32'(stall), 32'd1);
    chk("idle_req", 32'(bus_req), 32'd0);
    chk("idle_exc", 32'({adel, ades}), 32'd0);
    stalls += int'(stall);
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      // Inputs are scrambled while stalled; the unit must ignore them.
      bus_ack = 1'b0; bus_rdata = $urandom; addr = $urandom; wdata = $urandom;
      byteen = 3'($urandom_range(0, 7));
      #2;
      stalls += int'(stall);
      if (bus_req) begin
        reqs++;
        if (!got) begin
          got = 1'b1;
          if (exp_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
          else e = exp_q.pop_front();
        end
        chk("bus_addr", bus_addr, e.addr);
        chk("bus_be", 32'(bus_be), 32'(e.be));
        chk("bus_wdata", bus_wdata, e.wdata);
        chk("bus_we", 32'(bus_we), 32'(e.we));
        if (reqs == waits + 1) begin
          bus_ack = 1'b1;
          bus_rdata = mem_word;
        end
      end else begin
        done = 1'b1;
        chk("done_stall", 32'(stall), 32'd0);
        chk("done_got_req", 32'(got), 32'd1);
        chk("rdata", rdata, e.rdata);
        mem_read = 1'b0; mem_write = 1'b0;
      end
    end
    chk("done_seen", 32'(done), 32'd1);
    chk("stall_cycles", 32'(stalls), 32'(waits + 2));
  endtask

  task automatic run_misalign(input logic rd, input logic wr, input logic [2:0] code,
                              input logic [31:0] a, input logic exp_adel, input logic exp_ades);
    @(negedge clk);
    mem_read = rd; mem_write = wr; byteen = code; addr = a; wdata = 32'hFFFF_FFFF;
    #2;
    chk("mis_adel", 32'(adel), 32'(exp_adel));
    chk("mis_ades", 32'(ades), 32'(exp_ades));
    chk("mis_stall", 32'(stall), 32'd0);
    chk("mis_req", 32'(bus_req), 32'd0);
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
    #2;
    chk("mis_req_after", 32'(bus_req), 32'd0);
    chk("mis_exc_after", 32'({adel, ades}), 32'd0);
    chk("mis_rdata", rdata, last_rdata);
  endtask

  task automatic run_timeout();
    int reqs;
    bit fin;
    reqs = 0; fin = 1'b0;
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b0; byteen = 3'b000; addr = 32'h0000_3000; bus_ack = 1'b0;
    #2;
    chk("to_idle_stall", 32'(stall), 32'd1);
    for (int c = 0; c < 40 && !fin; c++) begin
      @(negedge clk);
      #2;
      if (bus_req) begin
        reqs++;
      end else begin
        fin = 1'b1;
        // mem_read is still high here: the aborted load must not restart.
        chk("to_bus_err", 32'(bus_err), 32'd1);
        chk("to_stall", 32'(stall), 32'd0);
        chk("to_rdata", rdata, 32'd0);
        mem_read = 1'b0;
      end
    end
    chk("to_finished", 32'(fin), 32'd1);
    chk("to_req_cycles", 32'(reqs), 32'd5);
    @(negedge clk);
    #2;
    chk("to_err_pulse", 32'(bus_err), 32'd0);
    chk("to_req_after", 32'(bus_req), 32'd0);
    last_rdata = '0;
  endtask

  task automatic run_reset_mid_wait();
    @(negedge clk);
    mem_write = 1'b1; mem_read = 1'b0; byteen = 3'b000; addr = 32'h0000_4008;
    wdata = 32'hCAFE_F00D; bus_ack = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_pre_req", 32'(bus_req), 32'd1);
    chk("rst_pre_we", 32'(bus_we), 32'd1);
    reset = 1'b0;
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_req", 32'(bus_req), 32'd0);
    chk("rst_we", 32'(bus_we), 32'd0);
    chk("rst_be", 32'(bus_be), 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_exc", 32'({adel, ades, bus_err}), 32'd0);
    mem_write = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 32'h55AA_55AA;
    @(negedge clk);
    bus_ack = 1'b0;
    #2;
    chk("late_ack_req", 32'(bus_req), 32'd0);
    chk("late_ack_stall", 32'(stall), 32'd0);
    chk("late_ack_rdata", rdata, 32'd0);
    last_rdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        r_rd;
    logic        r_wr;
    logic [2:0]  r_code;
    logic [31:0] r_a;
    logic [31:0] r_wd;
    logic [31:0] r_mw;
    exp_t        r_e;

    // Misaligned load presented during reset must raise nothing.
    reset = 1'b0; mem_read = 1'b1; mem_write = 1'b0; byteen = 3'b000;
    addr = 32'h0000_1002; wdata = 32'hFFFF_FFFF; bus_ack = 1'b0; bus_rdata = '0;
    repeat (2) @(negedge clk);
    #2;
    chk("por_stall", 32'(stall), 32'd0);
    chk("por_req", 32'(bus_req), 32'd0);
    chk("por_we", 32'(bus_we), 32'd0);
    chk("por_be", 32'(bus_be), 32'd0);
    chk("por_addr", bus_addr, 32'd0);
    chk("por_wdata", bus_wdata, 32'd0);
    chk("por_rdata", rdata, 32'd0);
    chk("por_exc", 32'({adel, ades, bus_err}), 32'd0);
    mem_read = 1'b0;
    // Deassert mid-cycle: the next rising edge must accept the first load.
    @(posedge clk);
    #2;
    reset = 1'b1;

    push_exp(32'h0000_1004, 4'b1111, 32'h0, 1'b0, 32'hDEAD_BEEF);
    run_access(1'b1, 1'b0, 3'b000, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 0);
    push_exp(32'h0000_1000, 4'b1000, 32'h0, 1'b0, 32'hFFFF_FF80);
    run_access(1'b1, 1'b0, 3'b011, 32'h0000_1003, 32'h0, 32'h8000_0000, 0);
    push_exp(32'h0000_1000, 4'b1000, 32'h0, 1'b0, 32'h0000_0080);
    run_access(1'b1, 1'b0, 3'b100, 32'h0000_1003, 32'h0, 32'h8000_0000, 0);
    push_exp(32'h0000_2000, 4'b1100, 32'hABCD_ABCD, 1'b1, 32'h0000_0080);
    run_access(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'h0BAD_F00D, 1);
    push_exp(32'h0000_3000, 4'b1100, 32'h0, 1'b0, 32'hFFFF_8765);
    run_access(1'b1, 1'b0, 3'b001, 32'h0000_3002, 32'h0, 32'h8765_1234, 3);
    push_exp(32'h0000_3000, 4'b0011, 32'h0, 1'b0, 32'h0000_F00D);
    run_access(1'b1, 1'b0, 3'b010, 32'h0000_3000, 32'h0, 32'h8765_F00D, 4);
    push_exp(32'h0000_5000, 4'b1111, 32'h1122_3344, 1'b1, 32'h0000_F00D);
    run_access(1'b1, 1'b1, 3'b000, 32'h0000_5000, 32'h1122_3344, 32'h9999_9999, 2);
    push_exp(32'h0000_6004, 4'b1111, 32'h0, 1'b0, 32'h0102_0304);
    run_access(1'b1, 1'b0, 3'b111, 32'h0000_6004, 32'h0, 32'h0102_0304, 1);

    run_misalign(1'b1, 1'b0, 3'b000, 32'h0000_1002, 1'b1, 1'b0);
    run_misalign(1'b0, 1'b1, 3'b000, 32'h0000_1001, 1'b0, 1'b1);
    run_misalign(1'b1, 1'b0, 3'b001, 32'h0000_1001, 1'b1, 1'b0);
    run_misalign(1'b0, 1'b1, 3'b010, 32'h0000_2003, 1'b0, 1'b1);

    run_timeout();

    for (int i = 0; i < 16; i++) begin
      r_code = 3'($urandom_range(0, 7));
      r_wr   = 1'($urandom_range(0, 1));
      r_rd   = r_wr ? 1'($urandom_range(0, 1)) : 1'b1;
      r_a    = $urandom;
      r_wd   = $urandom;
      r_mw   = $urandom;
      if (r_code == 3'b001 || r_code == 3'b010) r_a[0] = 1'b0;
      else if (!(r_code == 3'b011 || r_code == 3'b100)) r_a[1:0] = 2'b00;
      r_e = model(r_wr, r_code, r_a, r_wd, r_mw);
      exp_q.push_back(r_e);
      last_rdata = r_e.rdata;
      run_access(r_rd, r_wr, r_code, r_a, r_wd, r_mw, $urandom_range(0, 4));
    end

    push_exp(32'h0000_7000, 4'b1111, 32'h0, 1'b0, 32'h7777_1111);
    run_access(1'b1, 1'b0, 3'b000, 32'h0000_7000, 32'h0, 32'h7777_1111, 0);
    run_reset_mid_wait();
    push_exp(32'h0000_1004, 4'b1111, 32'h0, 1'b0, 32'h0BAD_CAFE);
    run_access(1'b1, 1'b0, 3'b000, 32'h0000_1004, 32'h0, 32'h0BAD_CAFE, 1);

    chk("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
